// File: rtl/risky_pkg.sv
// Shared core package: register-file geometry, index type and the
// opcode match constants that writeback uses to decide whether an
// instruction produces a destination register.
package risky_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int IDXW  = $clog2(NREGS);

  typedef logic [IDXW-1:0] reg_idx_t;

  // x0 is hard-wired to zero and is never stored or tracked.
  localparam reg_idx_t ZERO_REG = '0;

  // Major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // True for opcodes whose instruction writes rd; stores and branches do not.
  function automatic logic opc_writes_rd(input logic [6:0] opc);
    logic hit;
    hit = 1'b0;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP,
      OPC_LUI, OPC_JALR, OPC_JAL: hit = 1'b1;
      default:                    hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when
// decode claims a destination, cleared when writeback lands, wiped on flush.
// Produces the decode stall for read-after-write hazards.
module reg_scoreboard
  import risky_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     we_i,
  input  reg_idx_t sel_rd_i,
  input  logic     claim_i,
  input  reg_idx_t claim_rd_i,
  input  logic     flush_i,
  input  reg_idx_t sel_rs1_i,
  input  reg_idx_t sel_rs2_i,
  output logic     hazard_o
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic [NREGS-1:1] claim_hit;
  logic [NREGS-1:1] clear_hit;
  logic             hz_rs1;
  logic             hz_rs2;

  // x0 can never be pending.
  assign pending_d[0] = 1'b0;

  // Per-register next state: flush beats claim, claim beats the clearing
  // write (the newly issued instruction still owes a write).
  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_pend
      assign claim_hit[gi] = claim_i && (claim_rd_i == reg_idx_t'(gi));
      assign clear_hit[gi] = we_i && (sel_rd_i == reg_idx_t'(gi));
      assign pending_d[gi] = flush_i      ? 1'b0 :
                             claim_hit[gi] ? 1'b1 :
                             clear_hit[gi] ? 1'b0 :
                                             pending_q[gi];
    end
  endgenerate

  // Pending-bit register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A write landing this cycle is forwarded, so it satisfies the hazard.
  always_comb begin
    hz_rs1 = 1'b0;
    hz_rs2 = 1'b0;
    if (sel_rs1_i != ZERO_REG) begin
      hz_rs1 = pending_q[sel_rs1_i] && !(we_i && (sel_rd_i == sel_rs1_i));
    end
    if (sel_rs2_i != ZERO_REG) begin
      hz_rs2 = pending_q[sel_rs2_i] && !(we_i && (sel_rd_i == sel_rs2_i));
    end
    hazard_o = hz_rs1 || hz_rs2;
  end

endmodule

// File: rtl/reg_file.sv
// Architectural integer register file: one writeback write port, two
// decode read ports with write-first bypass, and the pending-write
// scoreboard that raises the decode stall.
module reg_file
  import risky_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IDXW-1:0] sel_rd_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [IDXW-1:0] sel_rs1_i,
  input  logic [IDXW-1:0] sel_rs2_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            claim_i,
  input  logic [IDXW-1:0] claim_rd_i,
  input  logic            flush_i,
  output logic            hazard_o
);

  // x0 is not stored: the array starts at index 1.
  logic [XLEN-1:0]  regs_q [1:NREGS-1];
  logic [NREGS-1:1] wr_sel;

  // One-hot write decode; index 0 has no entry, so x0 writes vanish here.
  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_wdec
      assign wr_sel[gi] = we_i && (sel_rd_i == reg_idx_t'(gi));
    end
  endgenerate

  // Register storage: asynchronous clear, decoded writeback update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_sel[i]) begin
          regs_q[i] <= data_i;
        end
      end
    end
  end

  // Source-1 read: x0 is zero, a same-cycle write is forwarded first.
  always_comb begin
    rs1_data_o = '0;
    if (sel_rs1_i != ZERO_REG) begin
      if (we_i && (sel_rd_i == sel_rs1_i)) begin
        rs1_data_o = data_i;
      end else begin
        rs1_data_o = regs_q[sel_rs1_i];
      end
    end
  end

  // Source-2 read: same bypass rules as source 1.
  always_comb begin
    rs2_data_o = '0;
    if (sel_rs2_i != ZERO_REG) begin
      if (we_i && (sel_rd_i == sel_rs2_i)) begin
        rs2_data_o = data_i;
      end else begin
        rs2_data_o = regs_q[sel_rs2_i];
      end
    end
  end

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (we_i),
    .sel_rd_i   (sel_rd_i),
    .claim_i    (claim_i),
    .claim_rd_i (claim_rd_i),
    .flush_i    (flush_i),
    .sel_rs1_i  (sel_rs1_i),
    .sel_rs2_i  (sel_rs2_i),
    .hazard_o   (hazard_o)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a reference model of the array and
// pending bits produces expected read/hazard values, which are queued
// when inputs are driven and compared when the outputs are sampled.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  sel_rd;
  logic        we;
  logic [31:0] data;
  logic [4:0]  sel_rs1;
  logic [4:0]  sel_rs2;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        claim;
  logic [4:0]  claim_rd;
  logic        flush;
  logic        hazard;

  always #5 clk = ~clk;

  reg_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_rd_i   (sel_rd),
    .we_i       (we),
    .data_i     (data),
    .sel_rs1_i  (sel_rs1),
    .sel_rs2_i  (sel_rs2),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .claim_i    (claim),
    .claim_rd_i (claim_rd),
    .flush_i    (flush),
    .hazard_o   (hazard)
  );

  typedef struct {
    string       tag;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        hz;
  } exp_t;

  exp_t        exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_regs [32];
  bit          m_pend [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (we && sel_rd == idx) return data;
    return m_regs[idx];
  endfunction

  function automatic logic m_hz(input logic [4:0] idx);
    if (idx == 5'd0) return 1'b0;
    return m_pend[idx] && !(we && sel_rd == idx);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic idle();
    we = 1'b0; sel_rd = 5'd0; data = 32'h0;
    claim = 1'b0; claim_rd = 5'd0; flush = 1'b0;
  endtask

  // Queue the expectation for the current inputs, then compare at negedge.
  task automatic sample(input string tag);
    exp_t e;
    e.tag = tag;
    e.rs1 = m_read(sel_rs1);
    e.rs2 = m_read(sel_rs2);
    e.hz  = m_hz(sel_rs1) | m_hz(sel_rs2);
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check({e.tag, ".rs1"}, rs1_data, e.rs1);
    check({e.tag, ".rs2"}, rs2_data, e.rs2);
    check({e.tag, ".hz"},  {31'b0, hazard}, {31'b0, e.hz});
  endtask

  // Clock edge: update the model with the inputs that were applied.
  task automatic advance();
    @(posedge clk);
    if (we && sel_rd != 5'd0) m_regs[sel_rd] = data;
    for (int k = 1; k < 32; k++) begin
      if (flush) m_pend[k] = 1'b0;
      else if (claim && claim_rd == k[4:0]) m_pend[k] = 1'b1;
      else if (we && sel_rd == k[4:0]) m_pend[k] = 1'b0;
    end
    #1;
  endtask

  function automatic logic [4:0] rnd_idx();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    int flush_ids [4];
    flush_ids = '{1, 2, 4, 9};
    rst_n = 1'b0;
    idle();
    sel_rs1 = 5'd5; sel_rs2 = 5'd31;
    model_reset();

    // Reset state
    sample("reset");
    check("reset_hz", {31'b0, hazard}, 32'h0);
    rst_n = 1'b1;
    advance();

    // Bypass write/read
    we = 1'b1; sel_rd = 5'd5; data = 32'h12345678; sel_rs1 = 5'd5; sel_rs2 = 5'd0;
    sample("byp");
    check("byp_same", rs1_data, 32'h12345678);
    advance();
    idle();
    sample("byp_next");
    check("byp_array", rs1_data, 32'h12345678);
    advance();

    // x0 write dropped
    we = 1'b1; sel_rd = 5'd0; data = 32'hDEADBEEF; sel_rs1 = 5'd0;
    sample("x0_wr");
    check("x0_same", rs1_data, 32'h0);
    advance();
    idle();
    sample("x0_after");
    check("x0_array", rs1_data, 32'h0);
    advance();

    // Load-use hazard on x7
    claim = 1'b1; claim_rd = 5'd7; sel_rs1 = 5'd0; sel_rs2 = 5'd0;
    sample("claim7");
    advance();
    idle();
    sel_rs2 = 5'd7;
    for (int c = 1; c <= 3; c++) begin
      sample("lu_wait");
      check("lu_hz_set", {31'b0, hazard}, 32'h1);
      advance();
    end
    we = 1'b1; sel_rd = 5'd7; data = 32'hFF;
    sample("lu_wb");
    check("lu_hz_clear", {31'b0, hazard}, 32'h0);
    check("lu_fwd", rs2_data, 32'hFF);
    advance();
    idle();
    sample("lu_done");
    check("lu_hz_after", {31'b0, hazard}, 32'h0);
    advance();

    // Claim and clear collide on x3
    claim = 1'b1; claim_rd = 5'd3; sel_rs2 = 5'd0; sel_rs1 = 5'd0;
    sample("claim3");
    advance();
    claim = 1'b1; claim_rd = 5'd3; we = 1'b1; sel_rd = 5'd3; data = 32'hA5A5A5A5;
    sel_rs1 = 5'd3;
    sample("collide");
    advance();
    idle();
    sample("collide_next");
    check("collide_hz", {31'b0, hazard}, 32'h1);
    check("collide_data", rs1_data, 32'hA5A5A5A5);
    advance();
    we = 1'b1; sel_rd = 5'd3; data = 32'h3;
    sample("clear3");
    advance();
    idle();

    // Flush with a same-cycle claim
    sel_rs1 = 5'd0;
    claim = 1'b1; claim_rd = 5'd1; sample("claim1"); advance();
    claim_rd = 5'd2; sample("claim2"); advance();
    claim_rd = 5'd9; sample("claim9"); advance();
    flush = 1'b1; claim_rd = 5'd4; sample("flush"); advance();
    idle();
    for (int j = 0; j < 4; j++) begin
      sel_rs1 = 5'(flush_ids[j]); sel_rs2 = 5'(flush_ids[j]);
      sample("post_flush");
      check("flush_hz", {31'b0, hazard}, 32'h0);
      advance();
    end

    // Random regression
    for (int n = 0; n < 10000; n++) begin
      we       = 1'($urandom_range(0, 1));
      sel_rd   = rnd_idx();
      data     = $urandom;
      claim    = ($urandom_range(0, 2) == 0);
      claim_rd = rnd_idx();
      flush    = ($urandom_range(0, 31) == 0);
      sel_rs1  = rnd_idx();
      sel_rs2  = rnd_idx();
      sample("rnd");
      advance();
    end

    // Mid-run asynchronous reset: everything reads 0, no hazard
    idle();
    rst_n = 1'b0;
    #1;
    for (int i = 1; i < 32; i++) begin
      sel_rs1 = 5'(i); sel_rs2 = 5'(i);
      #1;
      check("rst_rs1", rs1_data, 32'h0);
      check("rst_rs2", rs2_data, 32'h0);
      check("rst_hz", {31'b0, hazard}, 32'h0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    advance();
    for (int n = 0; n < 50; n++) begin
      we = 1'($urandom_range(0, 1)); sel_rd = rnd_idx(); data = $urandom;
      claim = 1'($urandom_range(0, 1)); claim_rd = rnd_idx(); flush = 1'b0;
      sel_rs1 = rnd_idx(); sel_rs2 = rnd_idx();
      sample("post_rst");
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
